// File: rtl/vga_timing_pkg.sv
// ---------------------------------------------------------------------------
// vga_timing_pkg
// Shared definitions for the VGA 640x480@60 timing generator.
//   - Default horizontal / vertical timing constants (in pixel ticks / lines)
//   - Derived line / frame totals
//   - Counter width used by both axis counters
//   - state_t: timing generator control state (IDLE / RUN)
//   - in_window(): half-open range test used for sync window decode
// ---------------------------------------------------------------------------
package vga_timing_pkg;

  // Both axis counters are 10 bits wide; 800 and 525 both fit.
  localparam int CNT_W = 10;

  // Horizontal timing, in pixel ticks.
  localparam int H_ACTIVE_DEF = 640;
  localparam int H_FP_DEF     = 16;
  localparam int H_SYNC_DEF   = 96;
  localparam int H_BP_DEF     = 48;
  localparam int H_TOTAL      = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;

  // Vertical timing, in lines.
  localparam int V_ACTIVE_DEF = 480;
  localparam int V_FP_DEF     = 10;
  localparam int V_SYNC_DEF   = 2;
  localparam int V_BP_DEF     = 33;
  localparam int V_TOTAL      = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // True when lo <= v < hi. Bounds are cast to the counter width so the
  // comparison is a plain unsigned compare of equal-width operands.
  function automatic logic in_window(input logic [CNT_W-1:0] v,
                                     input int               lo,
                                     input int               hi);
    logic [CNT_W-1:0] lo_w;
    logic [CNT_W-1:0] hi_w;
    lo_w = CNT_W'(lo);
    hi_w = CNT_W'(hi);
    return (v >= lo_w) && (v < hi_w);
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// ---------------------------------------------------------------------------
// vga_axis_counter
// One timing axis (horizontal or vertical). Counts 0..TOTAL-1 and wraps.
//
// Ports
//   inclok    in   1      system clock, rising edge
//   nrst      in   1      synchronous active-low reset (count -> 0)
//   clr       in   1      load 0 on this edge (priority over en)
//   en        in   1      advance the count on this edge
//   cnt       out  CNT_W  current count (registered)
//   sync_win  out  1      the count being loaded this edge lies in the sync pulse
//   active    out  1      the count being loaded this edge lies in the visible area
//   wrap      out  1      this edge advances the count from TOTAL-1 back to 0
//
// sync_win/active describe the NEXT count (cnt_d), so a parent can register
// its decoded outputs in the same edge as the counter and keep them exactly
// aligned with cnt without an extra cycle of latency.
// ---------------------------------------------------------------------------
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int ACTIVE = H_ACTIVE_DEF,
  parameter int FP     = H_FP_DEF,
  parameter int SYNC   = H_SYNC_DEF,
  parameter int BP     = H_BP_DEF
) (
  input  logic             inclok,
  input  logic             nrst,
  input  logic             clr,
  input  logic             en,
  output logic [CNT_W-1:0] cnt,
  output logic             sync_win,
  output logic             active,
  output logic             wrap
);

  localparam int               TOTAL      = ACTIVE + FP + SYNC + BP;
  localparam int               SYNC_START = ACTIVE + FP;
  localparam int               SYNC_END   = ACTIVE + FP + SYNC;
  localparam logic [CNT_W-1:0] LAST       = CNT_W'(TOTAL - 1);
  localparam logic [CNT_W-1:0] ACTIVE_W   = CNT_W'(ACTIVE);
  localparam logic [CNT_W-1:0] ONE        = CNT_W'(1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Wrap is detected by comparing against TOTAL-1 rather than relying on
  // the 10-bit counter overflowing, so non-power-of-two totals work.
  assign wrap = en & (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (wrap) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + ONE;
    end
  end

  assign sync_win = in_window(cnt_d, SYNC_START, SYNC_END);
  assign active   = (cnt_d < ACTIVE_W);

  always_ff @(posedge inclok) begin
    if (!nrst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/vga_timing_gen.sv
// ---------------------------------------------------------------------------
// vga_timing_gen
// VGA timing generator driven by the divided square wave from the clock
// divider. Each rising edge of outclok (seen as data in the inclok domain)
// is one pixel tick. While timeup is high (start-up delay still running)
// the generator sits idle with all outputs at their reset values.
//
// Ports
//   inclok       in   1   system clock, rising edge only
//   nrst         in   1   synchronous active-low reset, highest priority
//   outclok      in   1   divided square wave; rising edge = one pixel tick
//   timeup       in   1   1 = hold idle, 0 = run
//   hsync        out  1   horizontal sync, level SYNC_POL when asserted
//   vsync        out  1   vertical sync, level SYNC_POL when asserted
//   video_on     out  1   1 inside the visible window
//   px_x         out  10  horizontal counter 0..H_TOTAL-1
//   px_y         out  10  vertical counter 0..V_TOTAL-1
//   frame_start  out  1   one-cycle pulse when counters load (0,0)
//
// All outputs are registers updated in the same edge as the counters and
// decoded from the new counter values, so they are always consistent with
// px_x/px_y.
// ---------------------------------------------------------------------------
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int   H_ACTIVE = H_ACTIVE_DEF,
  parameter int   H_FP     = H_FP_DEF,
  parameter int   H_SYNC   = H_SYNC_DEF,
  parameter int   H_BP     = H_BP_DEF,
  parameter int   V_ACTIVE = V_ACTIVE_DEF,
  parameter int   V_FP     = V_FP_DEF,
  parameter int   V_SYNC   = V_SYNC_DEF,
  parameter int   V_BP     = V_BP_DEF,
  parameter logic SYNC_POL = 1'b0
) (
  input  logic             inclok,
  input  logic             nrst,
  input  logic             outclok,
  input  logic             timeup,
  output logic             hsync,
  output logic             vsync,
  output logic             video_on,
  output logic [CNT_W-1:0] px_x,
  output logic [CNT_W-1:0] px_y,
  output logic             frame_start
);

  // -------------------------------------------------------------------------
  // Control state and output registers
  // -------------------------------------------------------------------------
  state_t state_q;
  state_t state_d;
  logic   outclok_q;
  logic   hsync_q;
  logic   hsync_d;
  logic   vsync_q;
  logic   vsync_d;
  logic   video_on_q;
  logic   video_on_d;
  logic   frame_start_q;
  logic   frame_start_d;

  // -------------------------------------------------------------------------
  // Tick detection and counter control
  // -------------------------------------------------------------------------
  logic             tick;
  logic             run_go;
  logic             cnt_clr;
  logic             h_en;
  logic             v_en;
  logic             h_wrap;
  logic             v_wrap;
  logic             h_sync_win;
  logic             v_sync_win;
  logic             h_active;
  logic             v_active;
  logic [CNT_W-1:0] h_cnt;
  logic [CNT_W-1:0] v_cnt;
  logic             run_d;

  // outclok_q is cleared by reset, so a high outclok on the first edge after
  // reset release still counts as a rising edge.
  assign tick = outclok & ~outclok_q;

  // Counters only advance while staying in RUN; every other path (idle,
  // leaving RUN on timeup, entering RUN) loads them to zero.
  assign run_go  = (state_q == RUN) & ~timeup;
  assign cnt_clr = ~run_go;
  assign h_en    = run_go & tick;
  // h_wrap already includes the tick, so the vertical counter steps once per line.
  assign v_en    = h_wrap;

  vga_axis_counter #(
    .ACTIVE (H_ACTIVE),
    .FP     (H_FP),
    .SYNC   (H_SYNC),
    .BP     (H_BP)
  ) u_h_cnt (
    .inclok   (inclok),
    .nrst     (nrst),
    .clr      (cnt_clr),
    .en       (h_en),
    .cnt      (h_cnt),
    .sync_win (h_sync_win),
    .active   (h_active),
    .wrap     (h_wrap)
  );

  vga_axis_counter #(
    .ACTIVE (V_ACTIVE),
    .FP     (V_FP),
    .SYNC   (V_SYNC),
    .BP     (V_BP)
  ) u_v_cnt (
    .inclok   (inclok),
    .nrst     (nrst),
    .clr      (cnt_clr),
    .en       (v_en),
    .cnt      (v_cnt),
    .sync_win (v_sync_win),
    .active   (v_active),
    .wrap     (v_wrap)
  );

  // -------------------------------------------------------------------------
  // Next state and next output values
  // -------------------------------------------------------------------------
  always_comb begin
    state_d       = state_q;
    frame_start_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (tick && !timeup) begin
          state_d       = RUN;
          frame_start_d = 1'b1;
        end
      end
      RUN: begin
        // timeup wins over a coincident tick.
        if (timeup) begin
          state_d = IDLE;
        end else begin
          frame_start_d = v_wrap;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Decodes from the counter values being loaded this edge. In IDLE the
  // counters sit at zero, which would decode as visible, so everything is
  // gated with the next state.
  assign run_d      = (state_d == RUN);
  assign hsync_d    = (run_d && h_sync_win) ? SYNC_POL : ~SYNC_POL;
  assign vsync_d    = (run_d && v_sync_win) ? SYNC_POL : ~SYNC_POL;
  assign video_on_d = run_d & h_active & v_active;

  always_ff @(posedge inclok) begin
    if (!nrst) begin
      outclok_q     <= 1'b0;
      state_q       <= IDLE;
      hsync_q       <= ~SYNC_POL;
      vsync_q       <= ~SYNC_POL;
      video_on_q    <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      outclok_q     <= outclok;
      state_q       <= state_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      video_on_q    <= video_on_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign video_on    = video_on_q;
  assign frame_start = frame_start_q;
  assign px_x        = h_cnt;
  assign px_y        = v_cnt;

endmodule

// File: tb/tb_vga_timing_gen.sv
// ---------------------------------------------------------------------------
// tb_vga_timing_gen
// Two generators share the same inputs: dut0 with the standard 640x480
// timing, dut1 with a tiny 16x10 timing so whole frames fit in a short run.
// Stimulus drives inputs one inclok cycle at a time, updates a behavioural
// model of the expected timing and pushes expected snapshots (plus named
// hand-computed ones) into a queue; a monitor on the falling edge pops and
// compares them against the DUT outputs.
// ---------------------------------------------------------------------------
module tb_vga_timing_gen;

  logic       inclok = 1'b0;
  logic       nrst;
  logic       outclok;
  logic       timeup;

  logic       hs0, vs0, vo0, fs0;
  logic [9:0] x0, y0;
  logic       hs1, vs1, vo1, fs1;
  logic [9:0] x1, y1;

  vga_timing_gen dut0 (
    .inclok      (inclok),
    .nrst        (nrst),
    .outclok     (outclok),
    .timeup      (timeup),
    .hsync       (hs0),
    .vsync       (vs0),
    .video_on    (vo0),
    .px_x        (x0),
    .px_y        (y0),
    .frame_start (fs0)
  );

  vga_timing_gen #(
    .H_ACTIVE (8), .H_FP (2), .H_SYNC (3), .H_BP (3),
    .V_ACTIVE (6), .V_FP (1), .V_SYNC (2), .V_BP (1),
    .SYNC_POL (1'b0)
  ) dut1 (
    .inclok      (inclok),
    .nrst        (nrst),
    .outclok     (outclok),
    .timeup      (timeup),
    .hsync       (hs1),
    .vsync       (vs1),
    .video_on    (vo1),
    .px_x        (x1),
    .px_y        (y1),
    .frame_start (fs1)
  );

  always #5 inclok = ~inclok;

  int cyc    = 0;
  int checks = 0;
  int errors = 0;

  always @(posedge inclok) cyc <= cyc + 1;

  // ---------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------
  typedef struct {
    int    cyc;
    int    inst;
    bit    hand;
    string name;
    int    x;
    int    y;
    bit    hs;
    bit    vs;
    bit    vo;
    bit    fs;
  } exp_t;

  exp_t q[$];

  // Timing of each instance: active, front porch, sync, back porch.
  int p_ha  [2] = '{640, 8};
  int p_hfp [2] = '{16, 2};
  int p_hs  [2] = '{96, 3};
  int p_hbp [2] = '{48, 3};
  int p_va  [2] = '{480, 6};
  int p_vfp [2] = '{10, 1};
  int p_vs  [2] = '{2, 2};
  int p_vbp [2] = '{33, 1};

  // Behavioural model state
  bit m_prev = 1'b0;
  bit m_run [2];
  int m_x   [2];
  int m_y   [2];
  bit m_fs  [2];

  task automatic push_hand(input string nm, input int inst, input int x, input int y,
                           input bit hs, input bit vs, input bit vo, input bit fs);
    exp_t e;
    e.cyc = cyc; e.inst = inst; e.hand = 1'b1; e.name = nm;
    e.x = x; e.y = y; e.hs = hs; e.vs = vs; e.vo = vo; e.fs = fs;
    q.push_back(e);
  endtask

  task automatic model_update(input bit o, input bit t, input bit n);
    bit tk;
    tk = n && o && !m_prev;
    m_prev = n ? o : 1'b0;
    for (int i = 0; i < 2; i++) begin
      int htot;
      int vtot;
      htot = p_ha[i] + p_hfp[i] + p_hs[i] + p_hbp[i];
      vtot = p_va[i] + p_vfp[i] + p_vs[i] + p_vbp[i];
      m_fs[i] = 1'b0;
      if (!n) begin
        m_run[i] = 1'b0; m_x[i] = 0; m_y[i] = 0;
      end else if (!m_run[i]) begin
        if (tk && !t) begin
          m_run[i] = 1'b1; m_x[i] = 0; m_y[i] = 0; m_fs[i] = 1'b1;
        end
      end else if (t) begin
        m_run[i] = 1'b0; m_x[i] = 0; m_y[i] = 0;
      end else if (tk) begin
        if (m_x[i] == htot - 1) begin
          m_x[i] = 0;
          if (m_y[i] == vtot - 1) begin
            m_y[i] = 0;
            m_fs[i] = 1'b1;
          end else begin
            m_y[i] = m_y[i] + 1;
          end
        end else begin
          m_x[i] = m_x[i] + 1;
        end
      end
    end
  endtask

  task automatic push_model();
    for (int i = 0; i < 2; i++) begin
      exp_t e;
      int   hlo;
      int   vlo;
      hlo = p_ha[i] + p_hfp[i];
      vlo = p_va[i] + p_vfp[i];
      e.cyc = cyc; e.inst = i; e.hand = 1'b0; e.name = "model";
      e.x = m_x[i]; e.y = m_y[i]; e.fs = m_fs[i];
      e.hs = !(m_run[i] && m_x[i] >= hlo && m_x[i] < hlo + p_hs[i]);
      e.vs = !(m_run[i] && m_y[i] >= vlo && m_y[i] < vlo + p_vs[i]);
      e.vo = m_run[i] && m_x[i] < p_ha[i] && m_y[i] < p_va[i];
      q.push_back(e);
    end
  endtask

  // One inclok cycle: apply inputs, let the edge happen, record expectations.
  task automatic drive(input bit o, input bit t, input bit n);
    outclok = o; timeup = t; nrst = n;
    @(posedge inclok);
    #1;
    model_update(o, t, n);
    push_model();
  endtask

  task automatic tick_p4(input bit t);
    drive(1'b1, t, 1'b1);
    drive(1'b1, t, 1'b1);
    drive(1'b0, t, 1'b1);
    drive(1'b0, t, 1'b1);
  endtask

  task automatic tick_p2();
    drive(1'b1, 1'b0, 1'b1);
    drive(1'b0, 1'b0, 1'b1);
  endtask

  task automatic check_int(input string nm, input int act, input int req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, req);
    end else begin
      $display("ok   %s = %0d", nm, act);
    end
  endtask

  // ---------------------------------------------------------------------
  // Monitor
  // ---------------------------------------------------------------------
  exp_t mon_e;
  int   ax, ay;
  bit   ahs, avs, avo, afs;

  always @(negedge inclok) begin
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      mon_e = q.pop_front();
      if (mon_e.inst == 0) begin
        ax = int'(x0); ay = int'(y0); ahs = hs0; avs = vs0; avo = vo0; afs = fs0;
      end else begin
        ax = int'(x1); ay = int'(y1); ahs = hs1; avs = vs1; avo = vo1; afs = fs1;
      end
      checks++;
      if (mon_e.cyc != cyc || ax != mon_e.x || ay != mon_e.y || ahs != mon_e.hs ||
          avs != mon_e.vs || avo != mon_e.vo || afs != mon_e.fs) begin
        errors++;
        $display("FAIL %s dut%0d cyc %0d: got x=%0d y=%0d hs=%b vs=%b vo=%b fs=%b, expected x=%0d y=%0d hs=%b vs=%b vo=%b fs=%b (for cyc %0d)",
                 mon_e.name, mon_e.inst, cyc, ax, ay, ahs, avs, avo, afs,
                 mon_e.x, mon_e.y, mon_e.hs, mon_e.vs, mon_e.vo, mon_e.fs, mon_e.cyc);
      end else if (mon_e.hand) begin
        $display("ok   %s dut%0d cyc %0d: x=%0d y=%0d hs=%b vs=%b vo=%b fs=%b",
                 mon_e.name, mon_e.inst, cyc, ax, ay, ahs, avs, avo, afs);
      end
    end
  end

  // ---------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------
  typedef struct {
    int k;
    int x;
    int y;
    bit hs;
    bit vo;
  } line_pt_t;

  line_pt_t ltab [8] = '{
    '{639, 639, 0, 1'b1, 1'b1},
    '{640, 640, 0, 1'b1, 1'b0},
    '{655, 655, 0, 1'b1, 1'b0},
    '{656, 656, 0, 1'b0, 1'b0},
    '{751, 751, 0, 1'b0, 1'b0},
    '{752, 752, 0, 1'b1, 1'b0},
    '{799, 799, 0, 1'b1, 1'b0},
    '{800,   0, 1, 1'b1, 1'b1}
  };

  initial begin
    int hs_cnt;
    int vo_off_cnt;
    int fs_ticks [$];
    int vs_ticks;
    int vs_bad;
    int max_y;

    for (int i = 0; i < 2; i++) begin
      m_run[i] = 1'b0; m_x[i] = 0; m_y[i] = 0; m_fs[i] = 1'b0;
    end
    outclok = 1'b0; timeup = 1'b1; nrst = 1'b0;

    // Reset
    repeat (3) drive(1'b0, 1'b1, 1'b0);
    push_hand("reset", 0, 0, 0, 1'b1, 1'b1, 1'b0, 1'b0);
    push_hand("reset", 1, 0, 0, 1'b1, 1'b1, 1'b0, 1'b0);

    // Start-up delay running: ticks present but ignored
    repeat (1250) tick_p4(1'b1);
    push_hand("idle_hold", 0, 0, 0, 1'b1, 1'b1, 1'b0, 1'b0);

    // Release timeup: first rise starts at (0,0)
    drive(1'b1, 1'b0, 1'b1);
    push_hand("start", 0, 0, 0, 1'b1, 1'b1, 1'b1, 1'b1);
    push_hand("start", 1, 0, 0, 1'b1, 1'b1, 1'b1, 1'b1);
    drive(1'b1, 1'b0, 1'b1);
    push_hand("fs_width", 0, 0, 0, 1'b1, 1'b1, 1'b1, 1'b0);
    drive(1'b0, 1'b0, 1'b1);
    drive(1'b0, 1'b0, 1'b1);
    drive(1'b1, 1'b0, 1'b1);
    push_hand("x_inc", 0, 1, 0, 1'b1, 1'b1, 1'b1, 1'b0);
    drive(1'b1, 1'b0, 1'b1);
    drive(1'b0, 1'b0, 1'b1);
    drive(1'b0, 1'b0, 1'b1);

    // One full line on dut0
    hs_cnt = 0;
    vo_off_cnt = 0;
    for (int k = 2; k <= 800; k++) begin
      tick_p4(1'b0);
      if (k <= 799) begin
        if (hs0 == 1'b0) hs_cnt++;
        if (vo0 == 1'b0) vo_off_cnt++;
      end
      for (int j = 0; j < 8; j++) begin
        if (ltab[j].k == k) begin
          push_hand($sformatf("line_k%0d", k), 0, ltab[j].x, ltab[j].y,
                    ltab[j].hs, 1'b1, ltab[j].vo, 1'b0);
        end
      end
    end
    check_int("hsync_ticks_per_line", hs_cnt, 96);
    check_int("video_off_ticks_per_line", vo_off_cnt, 160);

    // Two full frames on the small instance, tick every other cycle
    drive(1'b0, 1'b1, 1'b1);
    vs_ticks = 0;
    vs_bad = 0;
    max_y = 0;
    for (int j = 0; j <= 324; j++) begin
      drive(1'b1, 1'b0, 1'b1);
      if (fs1 == 1'b1) fs_ticks.push_back(j);
      if (vs1 == 1'b0) begin
        vs_ticks++;
        if (y1 != 10'd7 && y1 != 10'd8) vs_bad++;
      end
      if (int'(y1) > max_y) max_y = int'(y1);
      drive(1'b0, 1'b0, 1'b1);
    end
    check_int("frame_start_count", fs_ticks.size(), 3);
    if (fs_ticks.size() == 3) begin
      check_int("frame_start_tick0", fs_ticks[0], 0);
      check_int("frame_start_tick1", fs_ticks[1], 160);
      check_int("frame_start_tick2", fs_ticks[2], 320);
    end
    check_int("vsync_ticks_two_frames", vs_ticks, 64);
    check_int("vsync_outside_490_491_equiv", vs_bad, 0);
    check_int("max_px_y", max_y, 9);

    // timeup mid-frame, coincident with a tick
    drive(1'b0, 1'b1, 1'b1);
    drive(1'b1, 1'b0, 1'b1);
    drive(1'b0, 1'b0, 1'b1);
    repeat (1100) tick_p2();
    push_hand("pre_timeup", 0, 300, 1, 1'b1, 1'b1, 1'b1, 1'b0);
    drive(1'b1, 1'b1, 1'b1);
    push_hand("timeup_prio", 0, 0, 0, 1'b1, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b1);
    push_hand("idle_no_tick", 0, 0, 0, 1'b1, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b1);
    push_hand("restart", 0, 0, 0, 1'b1, 1'b1, 1'b1, 1'b1);
    drive(1'b0, 1'b0, 1'b1);

    // nrst mid-line, coincident with a tick
    repeat (300) tick_p2();
    push_hand("pre_nrst", 0, 300, 0, 1'b1, 1'b1, 1'b1, 1'b0);
    drive(1'b1, 1'b0, 1'b0);
    push_hand("nrst_mid", 0, 0, 0, 1'b1, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b1);
    push_hand("nrst_restart", 0, 0, 0, 1'b1, 1'b1, 1'b1, 1'b1);

    // outclok held high: counters freeze, then resume one step per rise
    drive(1'b0, 1'b0, 1'b1);
    repeat (50) tick_p4(1'b0);
    push_hand("pre_hold", 0, 50, 0, 1'b1, 1'b1, 1'b1, 1'b0);
    repeat (100) drive(1'b1, 1'b0, 1'b1);
    push_hand("hold", 0, 51, 0, 1'b1, 1'b1, 1'b1, 1'b0);
    drive(1'b0, 1'b0, 1'b1);
    drive(1'b1, 1'b0, 1'b1);
    push_hand("resume", 0, 52, 0, 1'b1, 1'b1, 1'b1, 1'b0);
    drive(1'b0, 1'b0, 1'b1);
    drive(1'b1, 1'b0, 1'b1);
    push_hand("resume2", 0, 53, 0, 1'b1, 1'b1, 1'b1, 1'b0);
    drive(1'b0, 1'b0, 1'b1);

    // Let the monitor drain the queue
    repeat (3) @(negedge inclok);
    #1;
    check_int("scoreboard_drained", q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
